// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 1x3 router packet readers.
//   - rx_state_e      : packet reader FSM states
//   - hdr_len/hdr_addr: header field extraction ({len[7:2], addr[1:0]})
//   - NUM_PORTS       : number of router output ports
//   - DEFAULT_TIMEOUT : idle-cycle abort limit, also used by the router's
//                       soft-reset timeout
// ---------------------------------------------------------------------------
package router_pkg;

   localparam int NUM_PORTS       = 3;
   localparam int DEFAULT_TIMEOUT = 30;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      PAY,
      PAR,
      DONE
   } rx_state_e;

   function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
      return hdr[7:2];
   endfunction

   function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
      return hdr[1:0];
   endfunction

endpackage

// File: rtl/router_rx_skid.sv
// ---------------------------------------------------------------------------
// router_rx_skid
// Two-entry FIFO-ordered byte buffer between the packet parser and the
// payload consumer. The head entry drives the output directly, so valid and
// data come straight from registers.
// Ports:
//   clock, reset    : clock, synchronous active-high reset (flushes buffer)
//   push, push_data : write one byte (caller guarantees a free slot or a
//                     simultaneous pop)
//   pop             : remove the head byte (ignored when empty)
//   free            : number of empty slots (0..2)
//   valid, data     : head entry
// ---------------------------------------------------------------------------
module router_rx_skid (
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [1:0] free,
   output logic       valid,
   output logic [7:0] data
);

   logic [7:0] head_q, head_d;
   logic [7:0] tail_q, tail_d;
   logic [1:0] cnt_q, cnt_d;
   logic       pop_ok;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      pop_ok = pop && (cnt_q != 2'd0);
      unique case (cnt_q)
         2'd0: begin
            if (push) begin
               head_d = push_data;
               cnt_d  = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop_ok) begin
               head_d = push_data;
            end else if (push) begin
               tail_d = push_data;
               cnt_d  = 2'd2;
            end else if (pop_ok) begin
               cnt_d  = 2'd0;
            end
         end
         default: begin
            // Full: a pop shifts the tail forward; a push alongside it
            // refills the tail so occupancy stays at two.
            if (pop_ok) begin
               head_d = tail_q;
               if (push) begin
                  tail_d = push_data;
               end else begin
                  cnt_d  = 2'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q <= 8'd0;
         tail_q <= 8'd0;
         cnt_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   assign free  = 2'd2 - cnt_q;
   assign valid = (cnt_q != 2'd0);
   assign data  = head_q;

endmodule

// File: rtl/router_pkt_rx.sv
// ---------------------------------------------------------------------------
// router_pkt_rx
// Packet reader for one router output port. Drains the port FIFO, parses
// {len,addr} header + len payload bytes + XOR parity byte, forwards payload
// on a ready/valid stream and reports per-packet status.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   vld_out, data_out   : router FIFO non-empty / read data (1-cycle latency)
//   read_enb            : router FIFO read strobe
//   pl_data, pl_valid,
//   pl_ready            : payload stream to the consumer
//   pkt_done            : one-cycle pulse at packet end (normal or abort)
//   pkt_len, pkt_addr   : header fields of the last packet
//   parity_err, hdr_err,
//   timeout_err         : error flags of the last packet
//   pkt_count           : saturating count of error-free packets
// ---------------------------------------------------------------------------
module router_pkt_rx
   import router_pkg::*;
#(
   parameter int PORT_ID = 0,
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int CNT_W   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             vld_out,
   input  logic [7:0]       data_out,
   output logic             read_enb,
   output logic [7:0]       pl_data,
   output logic             pl_valid,
   input  logic             pl_ready,
   output logic             pkt_done,
   output logic [5:0]       pkt_len,
   output logic [1:0]       pkt_addr,
   output logic             parity_err,
   output logic             hdr_err,
   output logic             timeout_err,
   output logic [CNT_W-1:0] pkt_count
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   rx_state_e        state_q, state_d;
   logic [6:0]       issued_q, issued_d;     // reads issued for this packet
   logic [5:0]       pay_rcv_q, pay_rcv_d;   // payload bytes captured
   logic [5:0]       len_q, len_d;
   logic [1:0]       addr_q, addr_d;
   logic [7:0]       par_q, par_d;
   logic             perr_q, perr_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             rd_pend_q;              // byte arrives this cycle
   logic             pend_pay_q, pend_pay_d; // ... and it is a payload byte

   logic             pkt_done_q, pkt_done_d;
   logic [5:0]       pkt_len_q, pkt_len_d;
   logic [1:0]       pkt_addr_q, pkt_addr_d;
   logic             parity_err_q, parity_err_d;
   logic             hdr_err_q, hdr_err_d;
   logic             timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0] pkt_count_q, pkt_count_d;

   logic [1:0]       skid_free;
   logic             skid_push;
   logic             skid_pop;
   logic             in_pkt, abort, next_is_pay, need_more, credit_ok;
   logic             hdr_bad, rd_en;

   router_rx_skid u_skid (
      .clock     (clock),
      .reset     (reset),
      .push      (skid_push),
      .push_data (data_out),
      .pop       (skid_pop),
      .free      (skid_free),
      .valid     (pl_valid),
      .data      (pl_data)
   );

   assign skid_pop = pl_valid && pl_ready;

   // Read issue: depends only on registered state and vld_out.
   always_comb begin
      in_pkt      = (state_q == HDR) || (state_q == PAY) || (state_q == PAR);
      // Abort on the TIMEOUT-th consecutive cycle without a capture.
      abort       = in_pkt && !rd_pend_q && (to_cnt_q == TO_W'(TIMEOUT - 1));
      // Read index issued_q: 0 = header, 1..len = payload, len+1 = parity.
      next_is_pay = (issued_q != 7'd0) && (issued_q <= {1'b0, len_q});
      need_more   = issued_q < ({1'b0, len_q} + 7'd2);
      // A payload read needs a skid slot not already promised to the
      // payload byte that lands this cycle.
      credit_ok   = !next_is_pay ||
                    (skid_free > {1'b0, rd_pend_q && pend_pay_q});
      hdr_bad     = (len_q == 6'd0) || (addr_q == 2'd3) ||
                    (addr_q != 2'(PORT_ID));
      rd_en       = 1'b0;
      if (state_q == IDLE) begin
         rd_en = vld_out;
      end else if (((state_q == PAY) || (state_q == PAR)) && !abort) begin
         rd_en = vld_out && need_more && credit_ok;
      end
   end

   assign read_enb = rd_en;

   always_comb begin
      state_d       = state_q;
      issued_d      = issued_q;
      pay_rcv_d     = pay_rcv_q;
      len_d         = len_q;
      addr_d        = addr_q;
      par_d         = par_q;
      perr_d        = perr_q;
      pkt_done_d    = 1'b0;
      pkt_len_d     = pkt_len_q;
      pkt_addr_d    = pkt_addr_q;
      parity_err_d  = parity_err_q;
      hdr_err_d     = hdr_err_q;
      timeout_err_d = timeout_err_q;
      pkt_count_d   = pkt_count_q;
      skid_push     = 1'b0;
      pend_pay_d    = rd_en && next_is_pay && (state_q != IDLE);

      to_cnt_d = '0;
      if (in_pkt && !rd_pend_q) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end

      if (rd_en && (state_q != IDLE)) begin
         issued_d = issued_q + 7'd1;
      end

      unique case (state_q)
         IDLE: begin
            if (rd_en) begin
               state_d  = HDR;
               issued_d = 7'd1;
            end
         end
         HDR: begin
            if (rd_pend_q) begin
               len_d     = hdr_len(data_out);
               addr_d    = hdr_addr(data_out);
               par_d     = data_out;
               pay_rcv_d = 6'd0;
               state_d   = (hdr_len(data_out) == 6'd0) ? PAR : PAY;
            end
         end
         PAY: begin
            if (rd_pend_q) begin
               skid_push = 1'b1;
               par_d     = par_q ^ data_out;
               pay_rcv_d = pay_rcv_q + 6'd1;
               if (pay_rcv_q + 6'd1 == len_q) begin
                  state_d = PAR;
               end
            end
         end
         PAR: begin
            if (rd_pend_q) begin
               perr_d  = (par_q != data_out);
               state_d = DONE;
            end
         end
         DONE: begin
            pkt_done_d    = 1'b1;
            pkt_len_d     = len_q;
            pkt_addr_d    = addr_q;
            parity_err_d  = perr_q;
            hdr_err_d     = hdr_bad;
            timeout_err_d = 1'b0;
            if (!hdr_bad && !perr_q && (pkt_count_q != '1)) begin
               pkt_count_d = pkt_count_q + CNT_W'(1);
            end
            state_d  = IDLE;
            issued_d = 7'd0;
         end
         default: begin
            state_d  = IDLE;
            issued_d = 7'd0;
         end
      endcase

      // Abort leaves skid contents in place so they still drain.
      if (abort) begin
         state_d       = IDLE;
         issued_d      = 7'd0;
         pkt_done_d    = 1'b1;
         pkt_len_d     = len_q;
         pkt_addr_d    = addr_q;
         parity_err_d  = 1'b0;
         hdr_err_d     = hdr_bad;
         timeout_err_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         issued_q      <= 7'd0;
         pay_rcv_q     <= 6'd0;
         len_q         <= 6'd0;
         addr_q        <= 2'd0;
         par_q         <= 8'd0;
         perr_q        <= 1'b0;
         to_cnt_q      <= '0;
         rd_pend_q     <= 1'b0;
         pend_pay_q    <= 1'b0;
         pkt_done_q    <= 1'b0;
         pkt_len_q     <= 6'd0;
         pkt_addr_q    <= 2'd0;
         parity_err_q  <= 1'b0;
         hdr_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         pkt_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         issued_q      <= issued_d;
         pay_rcv_q     <= pay_rcv_d;
         len_q         <= len_d;
         addr_q        <= addr_d;
         par_q         <= par_d;
         perr_q        <= perr_d;
         to_cnt_q      <= to_cnt_d;
         rd_pend_q     <= rd_en;
         pend_pay_q    <= pend_pay_d;
         pkt_done_q    <= pkt_done_d;
         pkt_len_q     <= pkt_len_d;
         pkt_addr_q    <= pkt_addr_d;
         parity_err_q  <= parity_err_d;
         hdr_err_q     <= hdr_err_d;
         timeout_err_q <= timeout_err_d;
         pkt_count_q   <= pkt_count_d;
      end
   end

   assign pkt_done    = pkt_done_q;
   assign pkt_len     = pkt_len_q;
   assign pkt_addr    = pkt_addr_q;
   assign parity_err  = parity_err_q;
   assign hdr_err     = hdr_err_q;
   assign timeout_err = timeout_err_q;
   assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_router_pkt_rx.sv
// ---------------------------------------------------------------------------
// tb_router_pkt_rx
// Directed bench for router_pkt_rx (PORT_ID=1, TIMEOUT=30, CNT_W=2 so the
// saturating counter can be reached). A FIFO model feeds the DUT; expected
// payload bytes and packet status records are queued as stimulus is issued
// and a monitor pops and compares them whenever the DUT presents output.
// ---------------------------------------------------------------------------
module tb_router_pkt_rx;

   typedef struct packed {
      logic [5:0] len;
      logic [1:0] addr;
      logic       perr;
      logic       herr;
      logic       terr;
      logic [1:0] cnt;
   } st_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       vld_out;
   logic [7:0] data_out;
   logic       read_enb;
   logic [7:0] pl_data;
   logic       pl_valid;
   logic       pl_ready;
   logic       pkt_done;
   logic [5:0] pkt_len;
   logic [1:0] pkt_addr;
   logic       parity_err;
   logic       hdr_err;
   logic       timeout_err;
   logic [1:0] pkt_count;

   int         tests = 0;
   int         fails = 0;
   int         reads_total = 0;
   int         reads_base = 0;

   logic [7:0] fifo[$];
   logic [7:0] pl_src[$];
   logic [7:0] exp_pl[$];
   st_t        exp_st[$];

   router_pkt_rx #(.PORT_ID(1), .TIMEOUT(30), .CNT_W(2)) dut (
      .clock       (clock),
      .reset       (reset),
      .vld_out     (vld_out),
      .data_out    (data_out),
      .read_enb    (read_enb),
      .pl_data     (pl_data),
      .pl_valid    (pl_valid),
      .pl_ready    (pl_ready),
      .pkt_done    (pkt_done),
      .pkt_len     (pkt_len),
      .pkt_addr    (pkt_addr),
      .parity_err  (parity_err),
      .hdr_err     (hdr_err),
      .timeout_err (timeout_err),
      .pkt_count   (pkt_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Router FIFO: empty flag registered, read data one cycle after read_enb.
   task automatic fifo_model();
      logic re, rst;
      forever begin
         @(negedge clock);
         re  = read_enb;
         rst = reset;
         @(posedge clock);
         if (rst) begin
            fifo.delete();
         end else if (re && fifo.size() != 0) begin
            data_out <= fifo.pop_front();
            reads_total++;
         end
         vld_out <= !rst && (fifo.size() != 0);
      end
   endtask

   task automatic monitor();
      logic       hold;
      logic [7:0] hold_data;
      logic [7:0] e;
      st_t        s;
      hold      = 1'b0;
      hold_data = 8'd0;
      forever begin
         @(negedge clock);
         if (reset) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               check("pl_hold_valid", 32'(pl_valid), 32'd1);
               check("pl_hold_data", 32'(pl_data), 32'(hold_data));
            end
            if (read_enb) check("read_enb_needs_vld", 32'(vld_out), 32'd1);
            if (pl_valid && pl_ready) begin
               if (exp_pl.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL pl_unexpected: got byte %02h, required none", pl_data);
               end else begin
                  e = exp_pl.pop_front();
                  $display("[MON] payload %02h (expected %02h)", pl_data, e);
                  check("pl_data", 32'(pl_data), 32'(e));
               end
            end
            if (pkt_done) begin
               if (exp_st.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL pkt_done_unexpected: got pulse, required none");
               end else begin
                  s = exp_st.pop_front();
                  $display("[MON] pkt_done len=%0d addr=%0d perr=%0b herr=%0b terr=%0b cnt=%0d",
                           pkt_len, pkt_addr, parity_err, hdr_err, timeout_err, pkt_count);
                  check("status", 32'({pkt_len, pkt_addr, parity_err, hdr_err,
                                       timeout_err, pkt_count}), 32'(s));
               end
            end
            hold      = pl_valid && !pl_ready;
            hold_data = pl_data;
         end
      end
   endtask

   // Header + pl_src payload (+ parity, optionally corrupted by par_flip).
   task automatic send(input logic [7:0] hdr, input logic [7:0] par_flip,
                       input bit with_par, input bit expect_pl);
      logic [7:0] par;
      par = hdr;
      fifo.push_back(hdr);
      foreach (pl_src[i]) begin
         fifo.push_back(pl_src[i]);
         par = par ^ pl_src[i];
         if (expect_pl) exp_pl.push_back(pl_src[i]);
      end
      if (with_par) fifo.push_back(par ^ par_flip);
   endtask

   task automatic expect_st(input logic [5:0] len, input logic [1:0] addr,
                            input logic perr, input logic herr,
                            input logic terr, input logic [1:0] cnt);
      st_t s;
      s = '{len: len, addr: addr, perr: perr, herr: herr, terr: terr, cnt: cnt};
      exp_st.push_back(s);
   endtask

   task automatic finish_pkt(input int exp_reads, input int budget);
      int c;
      c = 0;
      while ((exp_st.size() != 0 || exp_pl.size() != 0) && c < budget) begin
         @(posedge clock);
         c++;
      end
      @(negedge clock);
      if (exp_st.size() != 0 || exp_pl.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_wait: %0d status and %0d bytes pending after %0d cycles, required 0",
                  exp_st.size(), exp_pl.size(), budget);
         exp_st.delete();
         exp_pl.delete();
      end
      repeat (2) @(posedge clock);
      #1;
      check("reads_per_pkt", 32'(reads_total - reads_base), 32'(exp_reads));
   endtask

   initial begin
      reset    = 1'b1;
      pl_ready = 1'b1;
      vld_out  = 1'b0;
      data_out = 8'd0;
      fork
         fifo_model();
         monitor();
      join_none

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_read_enb", 32'(read_enb), 32'd0);
      check("rst_pl_valid", 32'(pl_valid), 32'd0);
      check("rst_pkt_done", 32'(pkt_done), 32'd0);
      check("rst_status", 32'({pkt_len, pkt_addr, parity_err, hdr_err,
                               timeout_err, pkt_count}), 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;

      // 1: good packet 0D AA 55 0F FD
      pl_src = '{8'hAA, 8'h55, 8'h0F};
      reads_base = reads_total;
      send(8'h0D, 8'h00, 1'b1, 1'b1);
      expect_st(6'd3, 2'd1, 1'b0, 1'b0, 1'b0, 2'd1);
      finish_pkt(5, 100);

      // 2: parity byte FC instead of FD
      reads_base = reads_total;
      send(8'h0D, 8'h01, 1'b1, 1'b1);
      expect_st(6'd3, 2'd1, 1'b1, 1'b0, 1'b0, 2'd1);
      finish_pkt(5, 100);

      // 3: consumer stalls; reads must stop once two payload bytes buffered
      pl_ready   = 1'b0;
      reads_base = reads_total;
      send(8'h0D, 8'h00, 1'b1, 1'b1);
      expect_st(6'd3, 2'd1, 1'b0, 1'b0, 1'b0, 2'd2);
      repeat (12) @(posedge clock);
      #1;
      check("stall_reads", 32'(reads_total - reads_base), 32'd3);
      pl_ready = 1'b1;
      finish_pkt(5, 100);

      // 4: header 0A (len 2, addr 2) at port 1 -> hdr_err, still consumed
      pl_src = '{8'h11, 8'h22};
      reads_base = reads_total;
      send(8'h0A, 8'h00, 1'b1, 1'b1);
      expect_st(6'd2, 2'd2, 1'b0, 1'b1, 1'b0, 2'd2);
      finish_pkt(4, 100);

      // 5: header 15 (len 5) with only 2 payload bytes -> timeout abort
      pl_src = '{8'h01, 8'h02};
      reads_base = reads_total;
      send(8'h15, 8'h00, 1'b0, 1'b1);
      expect_st(6'd5, 2'd1, 1'b0, 1'b0, 1'b1, 2'd2);
      finish_pkt(3, 200);

      // 6: good packet after the abort
      pl_src = '{8'hAA, 8'h55, 8'h0F};
      reads_base = reads_total;
      send(8'h0D, 8'h00, 1'b1, 1'b1);
      expect_st(6'd3, 2'd1, 1'b0, 1'b0, 1'b0, 2'd3);
      finish_pkt(5, 100);

      // 7: reset in PAY discards the packet
      pl_ready   = 1'b0;
      reads_base = reads_total;
      send(8'h0D, 8'h00, 1'b1, 1'b0);
      repeat (8) @(posedge clock);
      #1;
      check("pre_rst_reads", 32'(reads_total - reads_base), 32'd3);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("midrst_read_enb", 32'(read_enb), 32'd0);
      check("midrst_pl_valid", 32'(pl_valid), 32'd0);
      check("midrst_pkt_count", 32'(pkt_count), 32'd0);
      @(posedge clock);
      #1 pl_ready = 1'b1;

      // 8: four back-to-back good packets; counter saturates at 3
      reads_base = reads_total;
      for (int k = 0; k < 4; k++) begin
         send(8'h0D, 8'h00, 1'b1, 1'b1);
         expect_st(6'd3, 2'd1, 1'b0, 1'b0, 1'b0, (k < 3) ? 2'(k + 1) : 2'd3);
      end
      finish_pkt(20, 300);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
